// File: rtl/ltpi_pkg.sv
// Shared LTPI definitions: UART lane FSM states, UART idle line levels and
// the port-id width helper used by the lane arbiter.
package ltpi_pkg;

    typedef enum logic [1:0] {
        L_IDLE   = 2'd0,
        L_ACTIVE = 2'd1,
        L_DRAIN  = 2'd2
    } lane_state_t;

    localparam logic UART_IDLE_TXD = 1'b1;
    localparam logic UART_IDLE_RTS = 1'b0;
    localparam logic UART_IDLE_RXD = 1'b1;
    localparam logic UART_IDLE_CTS = 1'b0;

    // Width of a port index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mgmt_uart_lane_fsm.sv
// Per-lane ownership FSM with saturating idle-frame counter.
// IDLE -> ACTIVE on grant; ACTIVE -> DRAIN after IDLE_FRAMES quiet frames;
// DRAIN -> IDLE on the next frame tick unless activity pulls it back.
module mgmt_uart_lane_fsm
    import ltpi_pkg::*;
#(
    parameter int unsigned IDLE_FRAMES = 256,
    parameter int unsigned IDW         = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            kill_i,          // link loss or owner disabled
    input  logic            grant_i,
    input  logic [IDW-1:0]  grant_id_i,
    input  logic            frame_tick_i,
    input  logic            owner_rxd_i,     // synced rxd of the owning port
    input  logic            owner_cts_chg_i, // synced cts of the owner toggled
    input  logic            lane_txd_i,
    input  logic            lane_rts_i,
    output lane_state_t     state_o,
    output logic [IDW-1:0]  owner_o
);

    localparam int unsigned    CW      = $clog2(IDLE_FRAMES + 1);
    localparam logic [CW-1:0]  CntLast = CW'(IDLE_FRAMES - 1);
    localparam logic [CW-1:0]  CntMax  = CW'(IDLE_FRAMES);

    lane_state_t    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           rts_prev_q, rts_prev_d;
    logic           activity;

    // Next-state, idle counter and owner capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        rts_prev_d = lane_rts_i;
        activity   = ~owner_rxd_i | ~lane_txd_i | owner_cts_chg_i | (lane_rts_i != rts_prev_q);

        unique case (state_q)
            L_IDLE: begin
                if (grant_i) begin
                    state_d = L_ACTIVE;
                    cnt_d   = '0;
                    owner_d = grant_id_i;
                end
            end
            L_ACTIVE: begin
                if (kill_i) begin
                    state_d = L_IDLE;
                end else if (activity) begin
                    cnt_d = '0;
                end else if (frame_tick_i) begin
                    if (cnt_q == CntLast) begin
                        state_d = L_DRAIN;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            L_DRAIN: begin
                if (kill_i) begin
                    state_d = L_IDLE;
                end else if (activity) begin
                    state_d = L_ACTIVE;
                    cnt_d   = '0;
                end else if (frame_tick_i) begin
                    state_d = L_IDLE;
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= L_IDLE;
            cnt_q      <= '0;
            owner_q    <= '0;
            rts_prev_q <= UART_IDLE_RTS;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            rts_prev_q <= rts_prev_d;
        end
    end

    assign state_o = state_q;
    assign owner_o = owner_q;

endmodule

// File: rtl/mgmt_uart_lane_arb.sv
// Arbitrates the LTPI frame UART lanes between local UART ports.
// A port claims the lowest free lane on its start bit (round-robin among
// pending ports) and keeps it until the lane FSM times it out.
// Optional build macro MGMT_UART_ARB_STATS_EN adds per-port deny counters.
module mgmt_uart_lane_arb
    import ltpi_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned IDLE_FRAMES = 256,
    localparam int unsigned IDW        = id_width(NUM_PORTS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     link_operational,
    input  logic                     frame_tick,
    input  logic [NUM_PORTS-1:0]     port_en,
    input  logic [NUM_PORTS-1:0]     port_rxd,
    input  logic [NUM_PORTS-1:0]     port_cts,
    output logic [NUM_PORTS-1:0]     port_txd,
    output logic [NUM_PORTS-1:0]     port_rts,
    output logic [NUM_LANES-1:0]     lane_rxd,
    output logic [NUM_LANES-1:0]     lane_cts,
    input  logic [NUM_LANES-1:0]     lane_txd,
    input  logic [NUM_LANES-1:0]     lane_rts,
    output logic [NUM_LANES-1:0]     lane_grant_vld,
`ifdef MGMT_UART_ARB_STATS_EN
    output logic [NUM_PORTS*8-1:0]   deny_cnt,
`endif
    output logic [NUM_LANES*IDW-1:0] lane_grant_id
);

    // s1/s2 form the synchronizer; d1/d2 delay the synced level so the
    // start bit that triggers a request still reaches the lane after grant.
    logic [NUM_PORTS-1:0] rxd_s1_q, rxd_s2_q, rxd_d1_q, rxd_d2_q;
    logic [NUM_PORTS-1:0] rxd_s1_d, rxd_s2_d, rxd_d1_d, rxd_d2_d;
    logic [NUM_PORTS-1:0] cts_s1_q, cts_s2_q, cts_d1_q, cts_d2_q;
    logic [NUM_PORTS-1:0] cts_s1_d, cts_s2_d, cts_d1_d, cts_d2_d;

    logic [NUM_PORTS-1:0] pending_q, pending_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] port_txd_q, port_txd_d;
    logic [NUM_PORTS-1:0] port_rts_q, port_rts_d;

    lane_state_t          lane_state [NUM_LANES];
    logic [IDW-1:0]       lane_owner [NUM_LANES];
    logic [NUM_LANES-1:0] lane_idle, first_idle, lane_grant, lane_kill;
    logic [NUM_LANES-1:0] owner_rxd, owner_cts_chg, owner_en, owner_rxd_dly, owner_cts_dly;
    logic [NUM_PORTS-1:0] owned, req, pend_vec, cand;
    logic                 found, any_free, do_grant;
    logic [IDW-1:0]       winner;
    int unsigned          idx;

    // Synchronizer and delay line next-state.
    always_comb begin
        rxd_s1_d = port_rxd;
        rxd_s2_d = rxd_s1_q;
        rxd_d1_d = rxd_s2_q;
        rxd_d2_d = rxd_d1_q;
        cts_s1_d = port_cts;
        cts_s2_d = cts_s1_q;
        cts_d1_d = cts_s2_q;
        cts_d2_d = cts_d1_q;
    end

    // Ownership map and per-lane view of the owning port.
    always_comb begin
        owned         = '0;
        lane_idle     = '0;
        owner_rxd     = '1;
        owner_cts_chg = '0;
        owner_en      = '0;
        owner_rxd_dly = '1;
        owner_cts_dly = '0;
        lane_kill     = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_idle[l] = (lane_state[l] == L_IDLE);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (lane_owner[l] == IDW'(p)) begin
                    owner_rxd[l]     = rxd_s2_q[p];
                    owner_cts_chg[l] = cts_s2_q[p] ^ cts_d1_q[p];
                    owner_en[l]      = port_en[p];
                    owner_rxd_dly[l] = rxd_d2_q[p];
                    owner_cts_dly[l] = cts_d2_q[p];
                    if (!lane_idle[l]) begin
                        owned[p] = 1'b1;
                    end
                end
            end
            lane_kill[l] = ~link_operational | ~owner_en[l];
        end
    end

    // Request capture and round-robin arbitration onto the lowest idle lane.
    always_comb begin
        req      = rxd_d1_q & ~rxd_s2_q & port_en & ~owned & {NUM_PORTS{link_operational}};
        pend_vec = pending_q | req;
        cand     = pend_vec & port_en & ~owned;

        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (32'(rr_ptr_q) + 32'(i)) % NUM_PORTS;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end

        any_free   = 1'b0;
        first_idle = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (!any_free && lane_idle[l]) begin
                any_free      = 1'b1;
                first_idle[l] = 1'b1;
            end
        end

        do_grant   = found & any_free & link_operational;
        lane_grant = do_grant ? first_idle : '0;

        pending_d = pend_vec & port_en;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (do_grant && winner == IDW'(p)) begin
                pending_d[p] = 1'b0;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (do_grant) begin
            rr_ptr_d = (32'(winner) == NUM_PORTS - 1) ? '0 : winner + IDW'(1);
        end

        if (!link_operational) begin
            pending_d = '0;
            rr_ptr_d  = '0;
        end
    end

    // Port-side outputs, registered; link loss and disable idle them at once.
    always_comb begin
        port_txd_d = {NUM_PORTS{UART_IDLE_TXD}};
        port_rts_d = {NUM_PORTS{UART_IDLE_RTS}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (link_operational && port_en[p] && !lane_idle[l] &&
                    lane_owner[l] == IDW'(p)) begin
                    port_rts_d[p] = lane_rts[l];
                    port_txd_d[p] = (lane_state[l] == L_ACTIVE) ? lane_txd[l] : UART_IDLE_TXD;
                end
            end
        end
    end

    // Lane-side outputs and grant status.
    always_comb begin
        lane_rxd       = {NUM_LANES{UART_IDLE_RXD}};
        lane_cts       = {NUM_LANES{UART_IDLE_CTS}};
        lane_grant_vld = ~lane_idle;
        lane_grant_id  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_state[l] == L_ACTIVE) begin
                lane_rxd[l] = owner_rxd_dly[l];
            end
            if (!lane_idle[l]) begin
                lane_cts[l]               = owner_cts_dly[l];
                lane_grant_id[l*IDW +: IDW] = lane_owner[l];
            end
        end
    end

    // Synchronizers, arbiter state and registered port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q   <= '1;
            rxd_s2_q   <= '1;
            rxd_d1_q   <= '1;
            rxd_d2_q   <= '1;
            cts_s1_q   <= '0;
            cts_s2_q   <= '0;
            cts_d1_q   <= '0;
            cts_d2_q   <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            port_txd_q <= {NUM_PORTS{UART_IDLE_TXD}};
            port_rts_q <= {NUM_PORTS{UART_IDLE_RTS}};
        end else begin
            rxd_s1_q   <= rxd_s1_d;
            rxd_s2_q   <= rxd_s2_d;
            rxd_d1_q   <= rxd_d1_d;
            rxd_d2_q   <= rxd_d2_d;
            cts_s1_q   <= cts_s1_d;
            cts_s2_q   <= cts_s2_d;
            cts_d1_q   <= cts_d1_d;
            cts_d2_q   <= cts_d2_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            port_txd_q <= port_txd_d;
            port_rts_q <= port_rts_d;
        end
    end

    assign port_txd = port_txd_q;
    assign port_rts = port_rts_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mgmt_uart_lane_fsm #(
            .IDLE_FRAMES (IDLE_FRAMES),
            .IDW         (IDW)
        ) u_fsm (
            .clk_i           (clk),
            .rst_ni          (reset_n),
            .kill_i          (lane_kill[l]),
            .grant_i         (lane_grant[l]),
            .grant_id_i      (winner),
            .frame_tick_i    (frame_tick),
            .owner_rxd_i     (owner_rxd[l]),
            .owner_cts_chg_i (owner_cts_chg[l]),
            .lane_txd_i      (lane_txd[l]),
            .lane_rts_i      (lane_rts[l]),
            .state_o         (lane_state[l]),
            .owner_o         (lane_owner[l])
        );
    end

`ifdef MGMT_UART_ARB_STATS_EN
    logic [NUM_PORTS*8-1:0] deny_q, deny_d;

    // Count requests that arrive while no lane is idle; saturate at 255.
    always_comb begin
        deny_d = deny_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!link_operational) begin
                deny_d[p*8 +: 8] = 8'h00;
            end else if (req[p] && lane_idle == '0 && deny_q[p*8 +: 8] != 8'hFF) begin
                deny_d[p*8 +: 8] = deny_q[p*8 +: 8] + 8'h01;
            end
        end
    end

    // Deny counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deny_q <= '0;
        end else begin
            deny_q <= deny_d;
        end
    end

    assign deny_cnt = deny_q;
`endif

endmodule

// File: tb/tb_mgmt_uart_lane_arb.sv
// Directed self-checking bench for mgmt_uart_lane_arb (4 ports, 2 lanes,
// IDLE_FRAMES = 4). Inputs change and outputs are sampled on the falling edge.
module tb_mgmt_uart_lane_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       link_operational;
    logic       frame_tick;
    logic [3:0] port_en, port_rxd, port_cts, port_txd, port_rts;
    logic [1:0] lane_rxd, lane_cts, lane_txd, lane_rts, lane_grant_vld;
    logic [3:0] lane_grant_id;
`ifdef MGMT_UART_ARB_STATS_EN
    logic [31:0] deny_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mgmt_uart_lane_arb #(
        .NUM_PORTS   (4),
        .NUM_LANES   (2),
        .IDLE_FRAMES (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .link_operational (link_operational),
        .frame_tick       (frame_tick),
        .port_en          (port_en),
        .port_rxd         (port_rxd),
        .port_cts         (port_cts),
        .port_txd         (port_txd),
        .port_rts         (port_rts),
        .lane_rxd         (lane_rxd),
        .lane_cts         (lane_cts),
        .lane_txd         (lane_txd),
        .lane_rts         (lane_rts),
        .lane_grant_vld   (lane_grant_vld),
`ifdef MGMT_UART_ARB_STATS_EN
        .deny_cnt         (deny_cnt),
`endif
        .lane_grant_id    (lane_grant_id)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic link_reset();
        link_operational = 1'b0;
        cyc(1);
        link_operational = 1'b1;
        cyc(3);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; link_operational = 1'b1; frame_tick = 1'b0;
        port_en = 4'hF; port_rxd = 4'hF; port_cts = 4'h0;
        lane_txd = 2'b11; lane_rts = 2'b00;
        cyc(3);
        checks++;
        if (port_txd !== 4'hF || port_rts !== 4'h0) begin
            errors++; $display("FAIL reset_port: txd=%b rts=%b expected 1111/0000", port_txd, port_rts);
        end
        checks++;
        if (lane_rxd !== 2'b11 || lane_cts !== 2'b00) begin
            errors++; $display("FAIL reset_lane: rxd=%b cts=%b expected 11/00", lane_rxd, lane_cts);
        end
        reset_n = 1'b1;
        cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b00 || lane_grant_id !== 4'h0) begin
            errors++; $display("FAIL reset_grant: vld=%b id=%h expected 00/0", lane_grant_vld, lane_grant_id);
        end
    endtask

    task automatic test_single_grant();
        port_rxd = 4'b1011;
        cyc(2);
        checks++;
        if (lane_grant_vld !== 2'b00) begin
            errors++; $display("FAIL single_early: vld=%b expected 00", lane_grant_vld);
        end
        cyc(1);
        checks++;
        if (lane_grant_vld !== 2'b01 || lane_grant_id[1:0] !== 2'd2) begin
            errors++; $display("FAIL single_grant: vld=%b id0=%0d expected 01/2", lane_grant_vld, lane_grant_id[1:0]);
        end
        cyc(1);
        checks++;
        if (lane_rxd !== 2'b10) begin
            errors++; $display("FAIL single_startbit: lane_rxd=%b expected 10", lane_rxd);
        end
        port_rxd = 4'hF;
        lane_txd = 2'b10; lane_rts = 2'b01;
        cyc(1);
        checks++;
        if (port_txd !== 4'b1011 || port_rts !== 4'b0100) begin
            errors++; $display("FAIL single_txd_rts: txd=%b rts=%b expected 1011/0100", port_txd, port_rts);
        end
        lane_txd = 2'b11; lane_rts = 2'b00;
        port_cts = 4'b0100;
        cyc(4);
        checks++;
        if (lane_cts !== 2'b01) begin
            errors++; $display("FAIL single_cts: lane_cts=%b expected 01", lane_cts);
        end
        port_cts = 4'h0;
        cyc(4);
        // rr_ptr is now 3, so port 3 beats port 0 for lane 1.
        port_rxd = 4'b0110;
        cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b11 || lane_grant_id[3:2] !== 2'd3) begin
            errors++; $display("FAIL single_rr: vld=%b id1=%0d expected 11/3", lane_grant_vld, lane_grant_id[3:2]);
        end
        port_rxd = 4'hF;
        link_reset();
    endtask

    task automatic test_multi_request();
        port_rxd = 4'b0100;
        cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b01 || lane_grant_id[1:0] !== 2'd0) begin
            errors++; $display("FAIL multi_lane0: vld=%b id0=%0d expected 01/0", lane_grant_vld, lane_grant_id[1:0]);
        end
        cyc(1);
        checks++;
        if (lane_grant_vld !== 2'b11 || lane_grant_id[3:2] !== 2'd1) begin
            errors++; $display("FAIL multi_lane1: vld=%b id1=%0d expected 11/1", lane_grant_vld, lane_grant_id[3:2]);
        end
        port_rxd = 4'hF;
        cyc(4);
        repeat (4) tick();
        checks++;
        if (lane_grant_vld !== 2'b11 || port_txd !== 4'hF) begin
            errors++; $display("FAIL multi_drain: vld=%b txd=%b expected 11/1111", lane_grant_vld, port_txd);
        end
        tick();
        checks++;
        if (lane_grant_vld !== 2'b00) begin
            errors++; $display("FAIL multi_release: vld=%b expected 00", lane_grant_vld);
        end
        cyc(1);
        checks++;
        if (lane_grant_vld !== 2'b01 || lane_grant_id[1:0] !== 2'd3) begin
            errors++; $display("FAIL multi_port3: vld=%b id0=%0d expected 01/3", lane_grant_vld, lane_grant_id[1:0]);
        end
    endtask

    task automatic test_drain_activity();
        repeat (4) tick();
        checks++;
        if (lane_grant_vld !== 2'b01) begin
            errors++; $display("FAIL drain_held: vld=%b expected 01", lane_grant_vld);
        end
        lane_txd = 2'b10;
        cyc(1);
        checks++;
        if (port_txd !== 4'hF) begin
            errors++; $display("FAIL drain_txd_forced: txd=%b expected 1111", port_txd);
        end
        lane_txd = 2'b11;
        cyc(1);
        tick();
        checks++;
        if (lane_grant_vld !== 2'b01) begin
            errors++; $display("FAIL drain_reactivated: vld=%b expected 01", lane_grant_vld);
        end
        repeat (3) tick();
        checks++;
        if (lane_grant_vld !== 2'b01) begin
            errors++; $display("FAIL drain_second: vld=%b expected 01", lane_grant_vld);
        end
        tick();
        checks++;
        if (lane_grant_vld !== 2'b00) begin
            errors++; $display("FAIL drain_release: vld=%b expected 00", lane_grant_vld);
        end
        cyc(2);
    endtask

    task automatic test_link_loss();
        port_rxd = 4'b1110;
        cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b01 || lane_grant_id[1:0] !== 2'd0) begin
            errors++; $display("FAIL link_grant: vld=%b id0=%0d expected 01/0", lane_grant_vld, lane_grant_id[1:0]);
        end
        lane_txd = 2'b10; lane_rts = 2'b01;
        cyc(1);
        checks++;
        if (port_txd !== 4'b1110 || port_rts !== 4'b0001 || lane_rxd !== 2'b10) begin
            errors++; $display("FAIL link_midbyte: txd=%b rts=%b lrxd=%b expected 1110/0001/10",
                               port_txd, port_rts, lane_rxd);
        end
        link_operational = 1'b0;
        cyc(1);
        checks++;
        if (lane_grant_vld !== 2'b00 || port_txd !== 4'hF || port_rts !== 4'h0 || lane_rxd !== 2'b11) begin
            errors++; $display("FAIL link_drop: vld=%b txd=%b rts=%b lrxd=%b expected 00/1111/0000/11",
                               lane_grant_vld, port_txd, port_rts, lane_rxd);
        end
        port_rxd = 4'b1010;
        cyc(4);
        link_operational = 1'b1;
        cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b00) begin
            errors++; $display("FAIL link_ignored_edge: vld=%b expected 00", lane_grant_vld);
        end
        port_rxd = 4'hF; lane_txd = 2'b11; lane_rts = 2'b00;
        cyc(3);
    endtask

    task automatic test_port_disable();
        port_rxd = 4'b1101;
        cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b01 || lane_grant_id[1:0] !== 2'd1) begin
            errors++; $display("FAIL dis_grant: vld=%b id0=%0d expected 01/1", lane_grant_vld, lane_grant_id[1:0]);
        end
        port_rxd = 4'hF; lane_rts = 2'b01;
        cyc(1);
        checks++;
        if (port_rts !== 4'b0010) begin
            errors++; $display("FAIL dis_rts: rts=%b expected 0010", port_rts);
        end
        port_en = 4'b1101;
        cyc(1);
        checks++;
        if (lane_grant_vld !== 2'b00 || port_rts !== 4'h0) begin
            errors++; $display("FAIL dis_release: vld=%b rts=%b expected 00/0000", lane_grant_vld, port_rts);
        end
        lane_rts = 2'b00;
        port_rxd = 4'b1101;
        cyc(4);
        checks++;
        if (lane_grant_vld !== 2'b00) begin
            errors++; $display("FAIL dis_no_grant: vld=%b expected 00", lane_grant_vld);
        end
        port_rxd = 4'hF;
        cyc(3);
        port_en = 4'hF;
        cyc(2);
    endtask

`ifdef MGMT_UART_ARB_STATS_EN
    task automatic test_deny_stats();
        link_reset();
        port_rxd = 4'b1110; cyc(3);
        port_rxd = 4'hF;    cyc(3);
        port_rxd = 4'b1101; cyc(3);
        port_rxd = 4'hF;    cyc(3);
        checks++;
        if (lane_grant_vld !== 2'b11) begin
            errors++; $display("FAIL deny_setup: vld=%b expected 11", lane_grant_vld);
        end
        for (int i = 0; i < 300; i++) begin
            port_rxd[3] = 1'b0; cyc(3);
            port_rxd[3] = 1'b1; cyc(3);
            if (i == 9) begin
                checks++;
                if (deny_cnt[31:24] !== 8'd10) begin
                    errors++; $display("FAIL deny_10: got %0d expected 10", deny_cnt[31:24]);
                end
            end
        end
        checks++;
        if (deny_cnt !== 32'hFF00_0000) begin
            errors++; $display("FAIL deny_sat: got %h expected ff000000", deny_cnt);
        end
        link_reset();
        checks++;
        if (deny_cnt !== 32'h0) begin
            errors++; $display("FAIL deny_clear: got %h expected 0", deny_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_multi_request();
        test_drain_activity();
        test_link_loss();
        test_port_disable();
`ifdef MGMT_UART_ARB_STATS_EN
        test_deny_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
